// File: rtl/answer_gen.sv
// Secret-number generator for the guessing game: draws 1..3 BCD digits from a
// free-running 16-bit Galois LFSR, one attempt per cycle with a bounded fallback.
module answer_gen #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_round,
    input  logic [1:0] max_digits,
    output logic [3:0] answer0,
    output logic [3:0] answer1,
    output logic [3:0] answer2,
    output logic       answer_valid,
    output logic       busy
);

    localparam logic [15:0] TAPS     = 16'hB400;
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_GEN0 = 3'd1;
    localparam logic [2:0] S_GEN1 = 3'd2;
    localparam logic [2:0] S_GEN2 = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]  state, state_n;
    logic [15:0] lfsr, lfsr_n;
    logic [1:0]  md_q, md_n;
    logic [1:0]  rej_q, rej_n;
    logic [3:0]  a0_n, a1_n, a2_n;
    logic        valid_n, busy_n;

    logic [1:0]  k;
    logic        lead;
    logic        need_nz;
    logic [3:0]  cand;
    logic [3:0]  fb;
    logic [3:0]  digit;
    logic        legal;
    logic        accept;

    // Galois step; the all-zero state is unreachable from a nonzero seed
    assign lfsr_n = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);

    always_comb begin
        state_n = state;
        md_n    = md_q;
        rej_n   = rej_q;
        a0_n    = answer0;
        a1_n    = answer1;
        a2_n    = answer2;
        valid_n = answer_valid;
        busy_n  = busy;

        k       = 2'(state - S_GEN0);
        lead    = (k == (md_q - 2'd1));
        need_nz = lead && (md_q > 2'd1);
        cand    = lfsr[3:0];
        fb      = {1'b0, lfsr[2:0]};
        if (need_nz && (fb == 4'd0)) begin
            fb = 4'd1;
        end
        legal   = (cand <= 4'd9) && !(need_nz && (cand == 4'd0));
        accept  = legal || (rej_q == 2'd3);
        digit   = (rej_q == 2'd3) ? fb : cand;

        case (state)
            S_IDLE, S_DONE: begin
                if (new_round) begin
                    md_n    = (max_digits == 2'd0) ? 2'd1 : max_digits;
                    a0_n    = 4'd0;
                    a1_n    = 4'd0;
                    a2_n    = 4'd0;
                    valid_n = 1'b0;
                    busy_n  = 1'b1;
                    rej_n   = 2'd0;
                    state_n = S_GEN0;
                end
            end
            S_GEN0, S_GEN1, S_GEN2: begin
                if (accept) begin
                    case (k)
                        2'd0:    a0_n = digit;
                        2'd1:    a1_n = digit;
                        default: a2_n = digit;
                    endcase
                    rej_n = 2'd0;
                    if (lead) begin
                        state_n = S_DONE;
                        valid_n = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        state_n = state + 3'd1;
                    end
                end else begin
                    rej_n = rej_q + 2'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
                valid_n = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            lfsr         <= SEED_EFF;
            md_q         <= 2'd1;
            rej_q        <= 2'd0;
            answer0      <= 4'd0;
            answer1      <= 4'd0;
            answer2      <= 4'd0;
            answer_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            lfsr         <= lfsr_n;
            md_q         <= md_n;
            rej_q        <= rej_n;
            answer0      <= a0_n;
            answer1      <= a1_n;
            answer2      <= a2_n;
            answer_valid <= valid_n;
            busy         <= busy_n;
        end
    end

endmodule

// File: doc/answer_gen.md
# answer_gen

Generates the hidden secret number for each round of the number-guessing game. Sits upstream of the hint/compare stage: it produces the answer digits (`answer0..answer2`, BCD) that the hint logic compares against the player's confirmed digits. The FSM requests a new secret at round start and supplies the difficulty (`max_digits`). Randomness comes from a free-running LFSR, so the value depends on when the player presses start.

## Interface
- `SEED`, default 16'hACE1: LFSR value loaded on reset. A value of 0 is replaced by 16'h0001.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `new_round`  in  1  single-cycle request to generate a new secret.
- `max_digits`  in  2  number of secret digits, 1..3. A value of 0 is treated as 1.
- `answer0`  out  4  ones digit, BCD 0..9.
- `answer1`  out  4  tens digit, BCD 0..9.
- `answer2`  out  4  hundreds digit, BCD 0..9.
- `answer_valid`  out  1  high while `answer0..answer2` hold a complete, stable secret.
- `busy`  out  1  high while generation is in progress.

## Operation
- **LFSR**
  - 16-bit Galois LFSR, right shift, tap mask 16'hB400.
  - Advances every cycle, including in IDLE and DONE.
  - Never enters the all-zero state.
- **State machine:** IDLE, GEN0, GEN1, GEN2, DONE.
- **IDLE/DONE + `new_round`:**
  - Latch `md_q` = (`max_digits`==0 ? 1 : `max_digits`).
  - Clear `answer0..answer2` to 0, drop `answer_valid`, set `busy`.
  - Clear the reject counter and go to GEN0.
- **GENk (k = 0,1,2), one attempt per cycle**
  - The candidate is `lfsr[3:0]`.
  - If k = `md_q`-1 (leading digit) and `md_q` > 1, the legal range is 1..9. Otherwise it is 0..9.
  - **Accept:** write the candidate to `answer_k` and clear the reject counter. If k = `md_q`-1, go to DONE. Otherwise go to GEN(k+1).
  - **Reject:** increment the 2-bit reject counter and stay in GENk.
  - **Fallback:** on the 4th attempt in the same GENk (counter == 3), force-accept {1'b0, `lfsr[2:0]`} (0..7). If that value is 0 and it is the leading digit, substitute 1.
- **DONE:** `answer_valid`=1, `busy`=0. Answers are held until the next accepted `new_round` or `rst`.
- **Unused digits:** digits at index ≥ `md_q` stay 0.
- **`new_round` while `busy`:** ignored and dropped. The in-progress generation is not restarted.
- **`max_digits` changes:** changes after the accept cycle have no effect until the next accepted `new_round`.
- **`rst`:** has priority over everything, including a simultaneous `new_round`. It forces IDLE, the LFSR to `SEED`, and the reject counter to 0. It is valid mid-generation.

## Timing
- **Reset values:** `answer0`=`answer1`=`answer2`=0, `answer_valid`=0, `busy`=0, state IDLE.
- **Registered outputs:** all outputs are registered; there is no combinational path from inputs to outputs.
- **Accept cycle N:** `new_round` is sampled high in cycle N (state IDLE/DONE). In N+1, `busy`=1 and `answer_valid`=0.
- **Best-case latency (every attempt accepted):** `answer_valid`=1 at N+1+`md_q`, i.e. N+2 / N+3 / N+4 for 1 / 2 / 3 digits.
- **Worst-case latency:** each digit takes at most 4 cycles, so `answer_valid`=1 no later than N+1+4·`md_q` (N+13 for 3 digits).
- **Digit write timing:** each `answer_k` updates the cycle after its accept.
- **Consumer rule:** consumers must qualify the digits with `answer_valid`.
- **Re-request in DONE:** a `new_round` in the DONE state drops `answer_valid` at the next edge.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `new_round`=1 held -> after release, all answers 0, `answer_valid`=0, `busy`=0, LFSR = 16'hACE1.
- **Three-digit generation:**
  - Stimulus: `SEED`=16'hACE1, `max_digits`=3, pulse `new_round` → compare every cycle against a bench LFSR/FSM model.
  - Required: `answer_valid` rises within 13 cycles; all digits ≤ 9; `answer2` ≠ 0.
- **Single digit / max_digits=0:** `max_digits`=1, then repeat with 0 -> `answer1`=`answer2`=0 and `answer0` in 0..9 in both cases; `answer_valid` within N+5.
- **Fallback path:**
  - Stimulus: choose a `SEED` whose next 4 nibbles are all ≥ 10 (find it from the model), `max_digits`=1.
  - Required: `answer0` = {0,`lfsr[2:0]`} at the 4th attempt, and `answer_valid` exactly at N+5.
- **Request while busy:** pulse `new_round` at N and again at N+2 -> a single generation; results match the model for the N request only; `busy` falls once.
- **Reset mid-generation:** assert `rst` at N+2 of a 3-digit request -> next cycle state IDLE, answers 0, `answer_valid`=0; a subsequent `new_round` produces the same digits as a run directly from reset.
